// File: rtl/adc_route_scheduler_pkg.sv
// Shared types and constants for the ADC route scheduler and its profile table.
package adc_route_scheduler_pkg;

    localparam int ADDR_W = 8;
    localparam int SEL_W  = 8;

    // A cfg write to this address clears the sticky select-error flag.
    localparam logic [ADDR_W-1:0] SEL_ERR_CLR_ADDR = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DWELL
    } state_t;

    function automatic int index_bits(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/adc_route_table.sv
// Dual-profile route register file: one synchronous write port, one combinational read port.
module adc_route_table
    import adc_route_scheduler_pkg::*;
#(
    parameter int  ENTRIES = 8,
    localparam int AW      = index_bits(ENTRIES)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             wr_prof_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [SEL_W-1:0] wr_data_i,
    input  logic             rd_prof_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [SEL_W-1:0] rd_data_o
);

    logic [SEL_W-1:0] mem_q [2][ENTRIES];

    // NOTE: no reset on the table so it maps onto RAM and survives a scheduler reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_prof_i][wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_prof_i][rd_addr_i];

endmodule

// File: rtl/adc_route_scheduler.sv
// Streams one of two route profiles into an interconnect mux, swapping profiles after a dwell of ADC samples.
module adc_route_scheduler
    import adc_route_scheduler_pkg::*;
#(
    parameter int IN_PORTS  = 16,
    parameter int OUT_PORTS = 8,
    parameter int DWELL_W   = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               cfg_we,
    input  logic               cfg_prof,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [SEL_W-1:0]   cfg_sel,
    input  logic               adc_valid,
    output logic               mux_wr,
    output logic [ADDR_W-1:0]  mux_addr,
    output logic [SEL_W-1:0]   mux_sel,
    output logic               busy,
    output logic               active_prof,
    output logic               switch_pulse,
    output logic               sel_err
);

    localparam int                AW       = index_bits(OUT_PORTS);
    localparam logic [ADDR_W:0]   OUT_LIM  = (ADDR_W + 1)'(OUT_PORTS);
    localparam logic [SEL_W:0]    IN_LIM   = (SEL_W + 1)'(IN_PORTS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUT_PORTS - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               prof_q, prof_d;
    logic               stop_q, stop_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               mux_wr_q, mux_wr_d;
    logic [ADDR_W-1:0]  mux_addr_q, mux_addr_d;
    logic [SEL_W-1:0]   mux_sel_q, mux_sel_d;
    logic               busy_q, busy_d;
    logic               active_prof_q, active_prof_d;
    logic               switch_q, switch_d;
    logic               sel_err_q, sel_err_d;

    logic               tbl_we;
    logic [SEL_W-1:0]   rd_sel;
    logic               sel_ok;
    logic               set_err;
    logic               clr_err;

    assign tbl_we = cfg_we && ({1'b0, cfg_addr} < OUT_LIM);

    adc_route_table #(
        .ENTRIES (OUT_PORTS)
    ) u_table (
        .clk       (clk),
        .we_i      (tbl_we),
        .wr_prof_i (cfg_prof),
        .wr_addr_i (cfg_addr[AW-1:0]),
        .wr_data_i (cfg_sel),
        .rd_prof_i (prof_q),
        .rd_addr_i (idx_q[AW-1:0]),
        .rd_data_o (rd_sel)
    );

    assign sel_ok  = ({1'b0, rd_sel} < IN_LIM);
    assign clr_err = cfg_we && (cfg_addr == SEL_ERR_CLR_ADDR);

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        prof_d        = prof_q;
        stop_d        = stop_q;
        cnt_d         = cnt_q;
        dwell_d       = dwell_q;
        mux_wr_d      = 1'b0;
        mux_addr_d    = mux_addr_q;
        mux_sel_d     = mux_sel_q;
        busy_d        = 1'b0;
        active_prof_d = active_prof_q;
        switch_d      = 1'b0;
        set_err       = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    prof_d  = 1'b0;
                    stop_d  = 1'b0;
                end
            end
            LOAD: begin
                mux_wr_d   = sel_ok;
                mux_addr_d = idx_q;
                mux_sel_d  = rd_sel;
                busy_d     = 1'b1;
                set_err    = !sel_ok;
                idx_d      = idx_q + 1'b1;
                if (!enable) stop_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    switch_d      = 1'b1;
                    active_prof_d = prof_q;
                    cnt_d         = '0;
                    dwell_d       = dwell;
                    state_d       = (stop_q || !enable) ? IDLE : DWELL;
                end
            end
            DWELL: begin
                // A latched dwell of zero never matches, which keeps the routing static.
                if (!enable) begin
                    state_d = IDLE;
                end else if (adc_valid && (dwell_q != '0)) begin
                    if (cnt_q == dwell_q - 1'b1) begin
                        state_d = LOAD;
                        prof_d  = !prof_q;
                        idx_d   = '0;
                        stop_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh error outranks a simultaneous clear so it is never lost.
        sel_err_d = set_err || (sel_err_q && !clr_err);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            prof_q        <= 1'b0;
            stop_q        <= 1'b0;
            cnt_q         <= '0;
            dwell_q       <= '0;
            mux_wr_q      <= 1'b0;
            mux_addr_q    <= '0;
            mux_sel_q     <= '0;
            busy_q        <= 1'b0;
            active_prof_q <= 1'b0;
            switch_q      <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            prof_q        <= prof_d;
            stop_q        <= stop_d;
            cnt_q         <= cnt_d;
            dwell_q       <= dwell_d;
            mux_wr_q      <= mux_wr_d;
            mux_addr_q    <= mux_addr_d;
            mux_sel_q     <= mux_sel_d;
            busy_q        <= busy_d;
            active_prof_q <= active_prof_d;
            switch_q      <= switch_d;
            sel_err_q     <= sel_err_d;
        end
    end

    assign mux_wr       = mux_wr_q;
    assign mux_addr     = mux_addr_q;
    assign mux_sel      = mux_sel_q;
    assign busy         = busy_q;
    assign active_prof  = active_prof_q;
    assign switch_pulse = switch_q;
    assign sel_err      = sel_err_q;

endmodule

// File: tb/tb_adc_route_scheduler.sv
// Randomized self-checking bench: a shadow route table plus dwell pulse counting predict every LOAD.
module tb_adc_route_scheduler;

    localparam int IN_PORTS  = 16;
    localparam int OUT_PORTS = 8;
    localparam int DWELL_W   = 16;

    logic               clk = 1'b0;
    logic               resetn;
    logic               enable;
    logic [DWELL_W-1:0] dwell;
    logic               cfg_we;
    logic               cfg_prof;
    logic [7:0]         cfg_addr;
    logic [7:0]         cfg_sel;
    logic               adc_valid;
    logic               mux_wr;
    logic [7:0]         mux_addr;
    logic [7:0]         mux_sel;
    logic               busy;
    logic               active_prof;
    logic               switch_pulse;
    logic               sel_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference view of the route table as written by the bench.
    logic [7:0] shadow [2][OUT_PORTS];

    adc_route_scheduler #(
        .IN_PORTS  (IN_PORTS),
        .OUT_PORTS (OUT_PORTS),
        .DWELL_W   (DWELL_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .dwell        (dwell),
        .cfg_we       (cfg_we),
        .cfg_prof     (cfg_prof),
        .cfg_addr     (cfg_addr),
        .cfg_sel      (cfg_sel),
        .adc_valid    (adc_valid),
        .mux_wr       (mux_wr),
        .mux_addr     (mux_addr),
        .mux_sel      (mux_sel),
        .busy         (busy),
        .active_prof  (active_prof),
        .switch_pulse (switch_pulse),
        .sel_err      (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic cfg_write(input bit prof, input logic [7:0] addr, input logic [7:0] sel);
        cfg_we   = 1'b1;
        cfg_prof = prof;
        cfg_addr = addr;
        cfg_sel  = sel;
        @(negedge clk);
        cfg_we = 1'b0;
        if (int'(addr) < OUT_PORTS) shadow[prof][int'(addr)] = sel;
    endtask

    // Delivers exactly n adc_valid pulses with random gaps; no LOAD may start meanwhile.
    task automatic send_pulses(input int n);
        int sent = 0;
        while (sent < n) begin
            check("dwell busy", busy, 1'b0);
            adc_valid = ($urandom_range(0, 2) != 0);
            if (adc_valid) sent++;
            @(negedge clk);
        end
        adc_valid = 1'b0;
    endtask

    // hook_kind: 1 drop enable, 2 rewrite entry 6 of the live profile, 3 assert reset.
    task automatic expect_load(input bit prof, input int exp_wait, input int hook_idx,
                               input int hook_kind, input string tag);
        int         t = 0;
        logic [7:0] e;
        logic [7:0] nv;
        while (!busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("%s latency", tag), t, exp_wait);
        for (int i = 0; i < OUT_PORTS; i++) begin
            cfg_we = 1'b0;
            e = shadow[prof][i];
            check($sformatf("%s addr%0d", tag, i), mux_addr, i);
            check($sformatf("%s wr%0d", tag, i), mux_wr, (int'(e) < IN_PORTS));
            if (int'(e) < IN_PORTS) check($sformatf("%s sel%0d", tag, i), mux_sel, e);
            check($sformatf("%s busy%0d", tag, i), busy, 1'b1);
            check($sformatf("%s switch%0d", tag, i), switch_pulse, (i == OUT_PORTS - 1));
            if (i == OUT_PORTS - 1) check($sformatf("%s active_prof", tag), active_prof, prof);
            if (i == hook_idx) begin
                case (hook_kind)
                    1: enable = 1'b0;
                    2: begin
                        nv       = 8'($urandom_range(0, IN_PORTS - 1));
                        cfg_we   = 1'b1;
                        cfg_prof = prof;
                        cfg_addr = 8'd6;
                        cfg_sel  = nv;
                        shadow[prof][6] = nv;
                    end
                    3: begin
                        check($sformatf("%s pre-reset sel_err", tag), sel_err, 1'b1);
                        resetn = 1'b0;
                        #1;
                        check("rst mux_wr", mux_wr, 1'b0);
                        check("rst mux_addr", mux_addr, 8'd0);
                        check("rst mux_sel", mux_sel, 8'd0);
                        check("rst busy", busy, 1'b0);
                        check("rst active_prof", active_prof, 1'b0);
                        check("rst switch", switch_pulse, 1'b0);
                        check("rst sel_err", sel_err, 1'b0);
                        return;
                    end
                    default: ;
                endcase
            end
            @(negedge clk);
        end
        cfg_we = 1'b0;
        check($sformatf("%s end busy", tag), busy, 1'b0);
        check($sformatf("%s end wr", tag), mux_wr, 1'b0);
        check($sformatf("%s end switch", tag), switch_pulse, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sw_cnt;
        int wr_cnt;
        int bz_cnt;
        int sent;

        resetn    = 1'b0;
        enable    = 1'b0;
        dwell     = 16'd4;
        cfg_we    = 1'b0;
        cfg_prof  = 1'b0;
        cfg_addr  = 8'd0;
        cfg_sel   = 8'd0;
        adc_valid = 1'b0;
        repeat (3) @(negedge clk);

        check("reset mux_wr", mux_wr, 1'b0);
        check("reset mux_addr", mux_addr, 8'd0);
        check("reset mux_sel", mux_sel, 8'd0);
        check("reset busy", busy, 1'b0);
        check("reset active_prof", active_prof, 1'b0);
        check("reset switch", switch_pulse, 1'b0);
        check("reset sel_err", sel_err, 1'b0);

        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < OUT_PORTS; i++) begin
            cfg_write(1'b0, 8'(i), 8'(i));
            cfg_write(1'b1, 8'(i), 8'(OUT_PORTS - 1 - i));
        end
        cfg_write(1'b0, 8'd9, 8'd5);
        cfg_write(1'b1, 8'd8, 8'd5);
        check("idle busy", busy, 1'b0);

        // Identity profile on first enable, then reversed profile after each dwell of 4.
        enable = 1'b1;
        expect_load(1'b0, 2, -1, 0, "boot");
        send_pulses(4);
        expect_load(1'b1, 1, -1, 0, "rev");
        send_pulses(4);
        expect_load(1'b0, 1, -1, 0, "ident");

        // Out-of-range select is skipped and latches a sticky error.
        cfg_write(1'b0, 8'd3, 8'd20);
        send_pulses(4);
        expect_load(1'b1, 1, -1, 0, "clean");
        check("sel_err clean", sel_err, 1'b0);
        send_pulses(4);
        expect_load(1'b0, 1, -1, 0, "bad");
        check("sel_err set", sel_err, 1'b1);
        send_pulses(4);
        expect_load(1'b1, 1, -1, 0, "sticky");
        check("sel_err sticky", sel_err, 1'b1);
        cfg_write(1'b0, 8'hFF, 8'd0);
        check("sel_err cleared", sel_err, 1'b0);

        // Random tables; entry 6 rewritten while the load is in flight.
        for (int i = 0; i < OUT_PORTS; i++) begin
            cfg_write(1'b0, 8'(i), 8'($urandom_range(0, IN_PORTS - 1)));
            cfg_write(1'b1, 8'(i), 8'($urandom_range(0, IN_PORTS - 1)));
        end
        send_pulses(4);
        expect_load(1'b0, 1, 2, 2, "live");

        // A dwell change mid-dwell only applies from the next dwell period.
        send_pulses(1);
        dwell = 16'd2;
        send_pulses(3);
        expect_load(1'b1, 1, -1, 0, "dw old");
        dwell = 16'd4;
        send_pulses(2);
        expect_load(1'b0, 1, -1, 0, "dw new");
        send_pulses(4);
        expect_load(1'b1, 1, -1, 0, "dw back");

        // Disable while dwelling: no further loads however many samples arrive.
        enable = 1'b0;
        repeat (20) begin
            adc_valid = ($urandom_range(0, 1) != 0);
            @(negedge clk);
            check("off busy", busy, 1'b0);
            check("off wr", mux_wr, 1'b0);
        end
        adc_valid = 1'b0;

        // Dwell 0: one load from profile 0, then static routing.
        dwell  = 16'd0;
        enable = 1'b1;
        expect_load(1'b0, 2, -1, 0, "static");
        sw_cnt = 0;
        wr_cnt = 0;
        bz_cnt = 0;
        sent   = 0;
        while (sent < 100) begin
            adc_valid = ($urandom_range(0, 3) != 0);
            if (adc_valid) sent++;
            @(negedge clk);
            if (switch_pulse) sw_cnt++;
            if (mux_wr) wr_cnt++;
            if (busy) bz_cnt++;
        end
        adc_valid = 1'b0;
        check("static switches", sw_cnt, 0);
        check("static writes", wr_cnt, 0);
        check("static busy", bz_cnt, 0);

        // Enable dropped at index 2: load completes, then idle.
        enable = 1'b0;
        repeat (2) @(negedge clk);
        dwell  = 16'd4;
        enable = 1'b1;
        expect_load(1'b0, 2, 2, 1, "drop");
        repeat (20) begin
            adc_valid = ($urandom_range(0, 1) != 0);
            @(negedge clk);
            check("drop idle busy", busy, 1'b0);
        end
        adc_valid = 1'b0;

        // Reset mid-load at index 4; restart must come from IDLE with the table intact.
        cfg_write(1'b0, 8'd1, 8'd17);
        enable = 1'b1;
        expect_load(1'b0, 2, 4, 3, "rst");
        repeat (2) @(negedge clk);
        check("rst hold wr", mux_wr, 1'b0);
        check("rst hold busy", busy, 1'b0);
        resetn = 1'b1;
        expect_load(1'b0, 2, -1, 0, "restart");
        check("restart sel_err", sel_err, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_route_scheduler.md
ADC_ROUTE_SCHEDULER -- requirements
Module: adc_route_scheduler

Interface
REQ-001 SHALL have parameter IN_PORTS, default 16: flat input-port count of the controlled interconnect.
REQ-002 SHALL have parameter OUT_PORTS, default 8: flat output-port count, i.e. the number of mux entries.
REQ-003 SHALL have parameter DWELL_W, default 16: width of the dwell counter.
REQ-004 SHALL have ports clk (in, 1, single clock for all logic) and resetn (in, 1, reset, asynchronous, active-low).
REQ-005 SHALL have ports enable (in, 1, run scheduler) and dwell (in, DWELL_W, valid-sample count per profile; 0 selects one-shot).
REQ-006 SHALL have ports cfg_we (in, 1), cfg_prof (in, 1), cfg_addr (in, 8) and cfg_sel (in, 8): profile-table write port.
REQ-007 SHALL have port adc_valid (in, 1): sample strobe of the controlled interconnect input.
REQ-008 SHALL have ports mux_wr (out, 1), mux_addr (out, 8) and mux_sel (out, 8): entry-write interface to the interconnect.
REQ-009 SHALL have ports busy (out, 1), active_prof (out, 1), switch_pulse (out, 1) and sel_err (out, 1, sticky).

Function
REQ-010 SHALL hold two route profiles (0/1), each OUT_PORTS entries of 8 bits.
REQ-011 SHALL write table[cfg_prof][cfg_addr] <= cfg_sel on clk when cfg_we=1 and cfg_addr<OUT_PORTS; other addresses ignored.
REQ-012 SHALL implement FSM states IDLE, LOAD, DWELL.
REQ-013 IDLE->LOAD SHALL occur on the cycle after enable is sampled 1; the first load uses profile 0.
REQ-014 In LOAD SHALL emit one entry per cycle, index 0..OUT_PORTS-1, with mux_wr=1, mux_addr=index and mux_sel=table[prof][index], registered outputs.
REQ-015 A LOAD of OUT_PORTS entries SHALL take exactly OUT_PORTS cycles; busy=1 throughout.
REQ-016 An entry with sel>=IN_PORTS SHALL NOT be written (mux_wr=0 that cycle), SHALL set sel_err, and SHALL still consume its cycle.
REQ-017 At LOAD end SHALL pulse switch_pulse for 1 cycle and update active_prof to the loaded profile in the same cycle.
REQ-018 After LOAD SHALL enter DWELL, reset the counter to 0 and increment on each adc_valid=1.
REQ-019 When counter reaches dwell-1 with adc_valid=1 SHALL toggle profile and return to LOAD on the next cycle.
REQ-020 With dwell=0 SHALL, after the load, remain in DWELL without switching (static routing).
REQ-021 Table writes during LOAD SHALL be visible to entries not yet emitted; emitted entries SHALL be unaffected until the next LOAD.
REQ-022 enable=0 during LOAD SHALL complete the current load and then go to IDLE; in DWELL SHALL go to IDLE the next cycle.
REQ-023 Re-enable from IDLE SHALL restart at profile 0.
REQ-024 dwell changes SHALL take effect at the next DWELL entry.
REQ-025 sel_err SHALL clear only on a cfg_we write with cfg_addr=8'hFF.

Reset
REQ-026 On resetn=0 SHALL set state IDLE, mux_wr=0, mux_addr=0, mux_sel=0, busy=0, active_prof=0, switch_pulse=0, sel_err=0 and counter=0.
REQ-027 Reset SHALL NOT clear the profile tables (RAM-inferable); a reset during LOAD aborts with no further mux_wr.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the 8-bit address/select widths and the sel_err clear-address constant 8'hFF.
REQ-029 SHALL use one sub-module, adc_route_table: a dual-profile register file with one write port and one read port.

Verification
REQ-030 Bench SHALL cover: OUT_PORTS=8, profile 0 = identity, enable=1 -> 8 consecutive mux_wr with addr 0..7 and sel 0..7, then switch_pulse=1, active_prof=0.
REQ-031 Bench SHALL cover: dwell=4, profile 1 = reversed (7..0) -> after 4 adc_valid pulses a LOAD emits sel 7..0 and active_prof=1; after 4 more, profile 0 reloads.
REQ-032 Bench SHALL cover: profile 0 entry 3 = 20 (IN_PORTS=16) -> no mux_wr at addr 3, sel_err=1 until a write to cfg_addr 8'hFF.
REQ-033 Bench SHALL cover: dwell=0 with 100 adc_valid pulses -> exactly one LOAD, no switch_pulse after the first.
REQ-034 Bench SHALL cover: enable dropped at LOAD index 2 -> indices 3..7 still emitted, then busy=0 and state IDLE.
REQ-035 Bench SHALL cover: resetn asserted at LOAD index 4 -> mux_wr=0 immediately, all outputs 0; re-enable restarts at index 0, profile 0, with table contents intact.
